riscv_str_seq_ctrl: RTL

//  Multi-cycle sequencer for the string-op unit in EX. Accepts one string op from ID/EX via valid/ready.

---
 rtl/riscv_str_seq_ctrl_pkg.sv | 46 ++++
 rtl/riscv_str_seq_ctrl_byte_xform.sv | 66 ++++++
 rtl/riscv_str_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_str_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_str_seq_ctrl_pkg
//
// Shared definitions for the string-op sequencer in EX:
//   - STR_OP_* operator encodings and their width
//   - sequencer FSM state type
//   - LEET substitution characters
//   - small ASCII classification helpers used by the byte transform
// -----------------------------------------------------------------------------
package riscv_str_seq_ctrl_pkg;

    // Operator encoding. Three bits leave room for encodings outside the
    // known set, which the sequencer must report as illegal.
    localparam int STR_OP_WIDTH = 3;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

    // Byte lanes in a 32-bit operand.
    localparam int STR_NUM_LANES = 4;

    typedef enum logic [1:0] {
        STR_IDLE,
        STR_BUSY,
        STR_DONE
    } str_seq_state_e;

    // LEET replacement digits.
    localparam logic [7:0] STR_LEET_A = 8'h34; // '4'
    localparam logic [7:0] STR_LEET_E = 8'h33; // '3'
    localparam logic [7:0] STR_LEET_I = 8'h31; // '1'
    localparam logic [7:0] STR_LEET_O = 8'h30; // '0'
    localparam logic [7:0] STR_LEET_S = 8'h35; // '5'
    localparam logic [7:0] STR_LEET_T = 8'h37; // '7'

    function automatic logic str_is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    function automatic logic str_is_upper(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

endpackage

// File: rtl/riscv_str_seq_ctrl_byte_xform.sv
// -----------------------------------------------------------------------------
// riscv_str_byte_xform
//
// Purely combinational per-byte ASCII transform.
//
// Ports:
//   operator_i  STR_OP_* selector
//   byte_i      source byte
//   byte_o      transformed byte (passes through for non-letters / unknown op)
//   illegal_o   operator is not one of the known STR_OP_* encodings
// -----------------------------------------------------------------------------
module riscv_str_byte_xform
    import riscv_str_seq_ctrl_pkg::*;
(
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [7:0]              byte_i,
    output logic [7:0]              byte_o,
    output logic                    illegal_o
);

    logic       is_lower;
    logic       is_upper;
    logic [7:0] folded;

    assign is_lower = str_is_lower(byte_i);
    assign is_upper = str_is_upper(byte_i);
    // Fold upper-case letters to lower-case so LEET needs one table only.
    assign folded   = is_upper ? (byte_i | 8'h20) : byte_i;

    always_comb begin
        byte_o    = byte_i;
        illegal_o = 1'b0;
        case (operator_i)
            STR_OP_UPPER: begin
                if (is_lower) byte_o = byte_i - 8'h20;
            end
            STR_OP_LOWER: begin
                if (is_upper) byte_o = byte_i + 8'h20;
            end
            STR_OP_LEET: begin
                case (folded)
                    8'h61:   byte_o = STR_LEET_A;
                    8'h65:   byte_o = STR_LEET_E;
                    8'h69:   byte_o = STR_LEET_I;
                    8'h6F:   byte_o = STR_LEET_O;
                    8'h73:   byte_o = STR_LEET_S;
                    8'h74:   byte_o = STR_LEET_T;
                    default: byte_o = byte_i;
                endcase
            end
            STR_OP_ROT13: begin
                // First half of each alphabet moves up 13, second half down 13:
                // the wrap stays inside the letter range of the same case.
                if (is_lower) begin
                    byte_o = (byte_i <= 8'h6D) ? byte_i + 8'd13 : byte_i - 8'd13;
                end else if (is_upper) begin
                    byte_o = (byte_i <= 8'h4D) ? byte_i + 8'd13 : byte_i - 8'd13;
                end
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_str_seq_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_str_seq_ctrl
//
// Multi-cycle sequencer for the string-op unit in EX. Takes one op from ID/EX
// (valid/ready), walks the operand byte lanes from byte0 upward,
// BYTES_PER_CYCLE lanes per cycle, and hands the assembled word to writeback
// (valid/ready). A flush aborts any in-flight op without producing a result.
//
// Parameters:
//   BYTES_PER_CYCLE  lanes transformed per cycle (1, 2 or 4)
//   NUM_LANES        byte lanes per operand (fixed at 4)
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid_i   op request valid
//   req_ready_o   ready to accept (IDLE only)
//   operator_i    STR_OP_* selector
//   operand_i     source word, byte0 = [7:0]
//   res_valid_o   result valid
//   res_ready_i   writeback accepts the result
//   result_o      transformed word, stable while res_valid_o=1
//   illegal_o     qualifies res_valid_o: operator was not a known STR_OP
//   busy_o        sequencer not IDLE
//   flush_i       abort in-flight op
// -----------------------------------------------------------------------------
module riscv_str_seq_ctrl
    import riscv_str_seq_ctrl_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1,
    parameter int NUM_LANES       = STR_NUM_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [31:0]             result_o,
    output logic                    illegal_o,
    output logic                    busy_o,
    input  logic                    flush_i
);

    localparam int LANE_W = $clog2(NUM_LANES);
    // One extra bit so the counter can also express NUM_LANES itself.
    localparam int CNT_W  = LANE_W + 1;
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BYTES_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_LANES - BYTES_PER_CYCLE);

    str_seq_state_e                state_q, state_d;
    logic [CNT_W-1:0]              lane_cnt_q, lane_cnt_d;
    logic [STR_OP_WIDTH-1:0]       op_q, op_d;
    logic [NUM_LANES-1:0][7:0]     operand_q, operand_d;
    logic [NUM_LANES-1:0][7:0]     acc_q, acc_d;
    logic                          illegal_q, illegal_d;

    logic                          accept;

    // Per-lane transform slice for the group currently being processed.
    logic [LANE_W-1:0]             lane_idx [BYTES_PER_CYCLE];
    logic [7:0]                    xf_in    [BYTES_PER_CYCLE];
    logic [7:0]                    xf_out   [BYTES_PER_CYCLE];
    logic                          xf_ill   [BYTES_PER_CYCLE];

    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_xform
        assign lane_idx[gi] = lane_cnt_q[LANE_W-1:0] + LANE_W'(gi);
        assign xf_in[gi]    = operand_q[lane_idx[gi]];

        riscv_str_byte_xform u_xform (
            .operator_i (op_q),
            .byte_i     (xf_in[gi]),
            .byte_o     (xf_out[gi]),
            .illegal_o  (xf_ill[gi])
        );
    end

    // Flush beats a coincident request.
    assign accept = req_valid_i && req_ready_o && !flush_i;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        op_d        = op_q;
        operand_d   = operand_q;
        acc_d       = acc_q;
        illegal_d   = illegal_q;

        req_ready_o = (state_q == STR_IDLE);
        busy_o      = (state_q != STR_IDLE);
        res_valid_o = (state_q == STR_DONE);
        result_o    = acc_q;
        illegal_o   = illegal_q && (state_q == STR_DONE);

        case (state_q)
            STR_IDLE: begin
                if (accept) begin
                    state_d    = STR_BUSY;
                    op_d       = operator_i;
                    operand_d  = operand_i;
                    lane_cnt_d = '0;
                    acc_d      = '0;
                    illegal_d  = 1'b0;
                end
            end
            STR_BUSY: begin
                for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
                    acc_d[lane_idx[g]] = xf_out[g];
                    if (xf_ill[g]) illegal_d = 1'b1;
                end
                if (lane_cnt_q == LAST_GRP) begin
                    state_d    = STR_DONE;
                    lane_cnt_d = '0;
                end else begin
                    lane_cnt_d = lane_cnt_q + CNT_STEP;
                end
            end
            STR_DONE: begin
                // No accept on the DONE->IDLE cycle: req_ready_o is low here.
                if (res_ready_i) state_d = STR_IDLE;
            end
            default: begin
                state_d = STR_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d    = STR_IDLE;
            lane_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q <= '0;
            op_q       <= '0;
            operand_q  <= '0;
            acc_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            acc_q      <= acc_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule
